ccu_snoop_ctrl: RTL and testbench
=================================

CCU_SNOOP_CTRL -- requirements
Module: ccu_snoop_ctrl

Interface
REQ-001 SHALL have parameter NbCores, default 2, number of cached cores attached to the snoop fabric (1..8).
REQ-002 SHALL have parameter AddrWidth, default 64, snoop address width.
REQ-003 SHALL have parameter TimeoutCycles, default 256, maximum wait for all CR responses (>=2).
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i  in  1  coherent snoop request from interconnect.
REQ-007 req_ready_o  out  1  request accepted when both valid and ready are high.
REQ-008 req_addr_i  in  AddrWidth  cache-line address to snoop.
REQ-009 req_snoop_i  in  4  ACE AC snoop type (ACSNOOP).
REQ-010 req_initiator_i  in  $clog2(NbCores) (min 1)  core that issued the request; never snooped.
REQ-011 ac_valid_o  out  NbCores  per-core AC valid.
REQ-012 ac_ready_i  in  NbCores  per-core AC ready.
REQ-013 ac_addr_o / ac_snoop_o  out  AddrWidth / 4  shared AC payload, broadcast to all cores.
REQ-014 cr_valid_i  in  NbCores  per-core CR valid.
REQ-015 cr_ready_o  out  NbCores  per-core CR ready.
REQ-016 cr_resp_i  in  NbCores x 5  per-core CRRESP: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
REQ-017 rsp_valid_o  out  1  aggregated response valid.
REQ-018 rsp_ready_i  in  1  consumer ready.
REQ-019 rsp_resp_o  out  5  OR-reduction of collected CRRESP bits; bit [1] is also set on timeout.
REQ-020 rsp_data_src_o  out  NbCores  one-hot mask of cores that reported DataTransfer.
REQ-021 rsp_timeout_o  out  1  timeout occurred for this transaction.

Function
REQ-022 The FSM SHALL have three states: IDLE, SNOOP and RESP.
REQ-023 In IDLE, req_ready_o SHALL be 1, and all other outputs SHALL be 0.
REQ-024 On request handshake, the block SHALL register the address and snoop type.
- Target mask = all cores except the initiator.
- ac_pend and cr_pend are both loaded with the target mask.
- Next state is SNOOP.
REQ-025 If the target mask is 0 (NbCores=1), the block SHALL go directly to RESP with rsp_resp_o=0 and rsp_data_src_o=0.
REQ-026 In SNOOP, ac_valid_o SHALL equal ac_pend.
- A bit clears on the cycle after its ac_ready_i is high.
- Once asserted for a core, the payload SHALL stay stable until that core's handshake.
REQ-027 cr_ready_o[i] SHALL be high in SNOOP only when cr_pend[i]=1 and ac_pend[i]=0.
- A CR arriving before that core's AC handshake is not accepted.
REQ-028 On each CR handshake, the block SHALL OR cr_resp_i[i] into the accumulator and clear cr_pend[i].
- If cr_resp_i[i][0]=1, bit i of rsp_data_src_o SHALL be set.
REQ-029 Multiple cores' AC and CR handshakes in the same cycle SHALL all be accepted in that cycle.
REQ-030 SNOOP SHALL go to RESP on the cycle after cr_pend becomes 0, or on timeout.
- Minimum latency from request handshake to rsp_valid_o is 3 cycles: AC, CR, RESP.
REQ-031 Timeout counter behaviour:
- Cleared on entry to SNOOP and incremented every SNOOP cycle.
- When it reaches TimeoutCycles-1 with cr_pend non-zero: go to RESP, set rsp_timeout_o=1 and rsp_resp_o[1]=1, and drop all ac_valid_o and cr_ready_o.
- The counter saturates and never wraps.
REQ-032 In RESP, rsp_valid_o SHALL be 1 with stable outputs until rsp_ready_i is high, then go to IDLE.
- req_ready_o SHALL stay 0 outside IDLE; there is no back-to-back overlap.
REQ-033 The accumulator, data source mask and timeout flag SHALL be cleared on every new request acceptance.
REQ-034 An out-of-range req_initiator_i (>=NbCores) SHALL produce a target mask of all cores.

Reset
REQ-035 While rst_i is high, the FSM SHALL be in IDLE.
- All masks, counter, accumulator and outputs are 0, except req_ready_o, which is 1 after reset is released.
REQ-036 Reset asserted mid-transaction SHALL abort it immediately (asynchronously).
- ac_valid_o and rsp_valid_o drop without completing any handshake.

Verification
REQ-037 NbCores=2, initiator 0, addr 0x8000_0000, snoop 0x1, core 1 ac_ready=1 and CR 0b01001 one cycle later -> ac_valid_o=0b10 for exactly 1 cycle, rsp_resp_o=0b01001, rsp_data_src_o=0b10, rsp_valid_o 3 cycles after accept.
REQ-038 NbCores=4, initiator 2, core 0 ac_ready delayed 5 cycles, CR 0b00100 from core 0, CR 0b01000 from cores 1 and 3 -> no AC/CR on core 2, ac_addr_o stable throughout, rsp_resp_o=0b01100, rsp_data_src_o=0.
REQ-039 NbCores=2, core 1 never sends CR, TimeoutCycles=16 -> RESP after 16 SNOOP cycles, rsp_timeout_o=1, rsp_resp_o[1]=1, cr_ready_o=0 in RESP.
REQ-040 RESP held with rsp_ready_i=0 for 10 cycles while req_valid_i=1 -> outputs stable, req_ready_o=0; the new request is accepted the cycle after the RESP handshake and the accumulator is cleared.
REQ-041 NbCores=1, request accepted -> no AC issued, rsp_valid_o the next cycle with rsp_resp_o=0.
REQ-042 rst_i pulsed during SNOOP with ac_valid_o=0b10 -> ac_valid_o=0 asynchronously, req_ready_o=1 after release, and the next transaction completes normally.

Source files
------------

// File: rtl/ccu_snoop_ctrl.sv
// Purpose: broadcasts one coherent snoop to every core except the initiator, then merges the CR responses.
// Latency: at least 3 cycles from request accept to rsp_valid_o (AC, CR, RESP), or TimeoutCycles SNOOP cycles if a CR never arrives.
// Backpressure: one transaction at a time; req_ready_o is high only in IDLE, and RESP holds until rsp_ready_i.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid/ready/addr/snoop/initiator  incoming snoop request (valid/ready)
//   ac_valid_o/ac_ready_i             per-core AC handshake; ac_addr_o/ac_snoop_o are broadcast to all cores
//   cr_valid_i/cr_ready_o/cr_resp_i   per-core CR handshake, 5-bit CRRESP per core
//   rsp_valid/ready/resp/data_src/timeout  merged response back to the interconnect
module ccu_snoop_ctrl #(
  parameter int NbCores       = 2,
  parameter int AddrWidth     = 64,
  parameter int TimeoutCycles = 256
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              req_valid_i,
  output logic                                              req_ready_o,
  input  logic [AddrWidth-1:0]                              req_addr_i,
  input  logic [3:0]                                        req_snoop_i,
  input  logic [((NbCores > 1) ? $clog2(NbCores) : 1)-1:0]  req_initiator_i,
  output logic [NbCores-1:0]                                ac_valid_o,
  input  logic [NbCores-1:0]                                ac_ready_i,
  output logic [AddrWidth-1:0]                              ac_addr_o,
  output logic [3:0]                                        ac_snoop_o,
  input  logic [NbCores-1:0]                                cr_valid_i,
  output logic [NbCores-1:0]                                cr_ready_o,
  input  logic [NbCores*5-1:0]                              cr_resp_i,
  output logic                                              rsp_valid_o,
  input  logic                                              rsp_ready_i,
  output logic [4:0]                                        rsp_resp_o,
  output logic [NbCores-1:0]                                rsp_data_src_o,
  output logic                                              rsp_timeout_o
);

  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [3:0]             snoop_q;
  logic [NbCores-1:0]     ac_pend_q;
  logic [NbCores-1:0]     cr_pend_q;
  logic [4:0]             acc_q;
  logic [NbCores-1:0]     src_q;
  logic                   tmo_q;
  logic [CntW-1:0]        cnt_q;

  logic                   in_snoop;
  logic                   req_hs;
  logic [NbCores-1:0]     target_mask;
  logic [NbCores-1:0]     ac_hs;
  logic [NbCores-1:0]     cr_hs;
  logic [NbCores-1:0]     cr_pend_nxt;
  logic [4:0]             acc_nxt;
  logic [NbCores-1:0]     src_nxt;
  logic                   tmo_hit;

  assign in_snoop = (state_q == SNOOP);

  // Held low while reset is asserted so nothing is accepted until release.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign req_hs      = req_valid_i && req_ready_o;

  // Payload comes from registers, so it cannot move until the last AC handshake.
  assign ac_valid_o = in_snoop ? ac_pend_q : '0;
  assign ac_addr_o  = in_snoop ? addr_q    : '0;
  assign ac_snoop_o = in_snoop ? snoop_q   : '0;
  // A core's CR is only taken once its AC has been handshaken.
  assign cr_ready_o = in_snoop ? (cr_pend_q & ~ac_pend_q) : '0;

  assign ac_hs       = ac_valid_o & ac_ready_i;
  assign cr_hs       = cr_valid_i & cr_ready_o;
  assign cr_pend_nxt = cr_pend_q & ~cr_hs;

  // Out-of-range initiators match no index, so every core is snooped.
  always_comb begin
    target_mask = '0;
    for (int i = 0; i < NbCores; i++) begin
      target_mask[i] = (int'(req_initiator_i) != i);
    end
  end

  always_comb begin
    acc_nxt = acc_q;
    src_nxt = src_q;
    for (int i = 0; i < NbCores; i++) begin
      if (cr_hs[i]) begin
        acc_nxt    = acc_nxt | cr_resp_i[i*5 +: 5];
        src_nxt[i] = src_q[i] | cr_resp_i[i*5];
      end
    end
  end

  // Responses landing in the final cycle still count; timeout only if some remain outstanding.
  assign tmo_hit = in_snoop && (cnt_q == CntMax) && (cr_pend_nxt != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rsp_valid_o    = 1'b0;
    rsp_resp_o     = '0;
    rsp_data_src_o = '0;
    rsp_timeout_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d = (target_mask != '0) ? SNOOP : RESP;
        end
      end
      SNOOP: begin
        if ((cr_pend_nxt == '0) || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o    = 1'b1;
        rsp_resp_o     = acc_q;
        rsp_data_src_o = src_q;
        rsp_timeout_o  = tmo_q;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      snoop_q   <= '0;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      acc_q     <= '0;
      src_q     <= '0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_hs) begin
            addr_q    <= req_addr_i;
            snoop_q   <= req_snoop_i;
            ac_pend_q <= target_mask;
            cr_pend_q <= target_mask;
            acc_q     <= '0;
            src_q     <= '0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
          end
        end
        SNOOP: begin
          src_q <= src_nxt;
          tmo_q <= tmo_hit;
          if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (tmo_hit) begin
            // Abandon the stragglers: no further AC or CR is offered.
            ac_pend_q <= '0;
            cr_pend_q <= '0;
            acc_q     <= acc_nxt | 5'b00010;
          end else begin
            ac_pend_q <= ac_pend_q & ~ac_hs;
            cr_pend_q <= cr_pend_nxt;
            acc_q     <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_snoop_ctrl.sv
module tb_ccu_snoop_ctrl;

  typedef struct packed {
    logic [4:0] resp;
    logic [3:0] src;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_v, obs_v;
  int   checks = 0;
  int   failures = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a_: NbCores=2, TimeoutCycles=16
  logic        a_req_valid, a_req_ready, a_req_init;
  logic [63:0] a_req_addr, a_ac_addr;
  logic [3:0]  a_req_snoop, a_ac_snoop;
  logic [1:0]  a_ac_valid, a_ac_ready, a_cr_valid, a_cr_ready, a_rsp_src;
  logic [9:0]  a_cr_resp;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_tmo;
  logic [4:0]  a_rsp_resp;

  // b_: NbCores=4
  logic        b_req_valid, b_req_ready;
  logic [1:0]  b_req_init;
  logic [63:0] b_req_addr, b_ac_addr;
  logic [3:0]  b_req_snoop, b_ac_snoop;
  logic [3:0]  b_ac_valid, b_ac_ready, b_cr_valid, b_cr_ready, b_rsp_src;
  logic [19:0] b_cr_resp;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_tmo;
  logic [4:0]  b_rsp_resp;

  // c_: NbCores=1
  logic        c_req_valid, c_req_ready, c_req_init;
  logic [63:0] c_req_addr, c_ac_addr;
  logic [3:0]  c_req_snoop, c_ac_snoop;
  logic        c_ac_valid, c_ac_ready, c_cr_valid, c_cr_ready, c_rsp_src;
  logic [4:0]  c_cr_resp;
  logic        c_rsp_valid, c_rsp_ready, c_rsp_tmo;
  logic [4:0]  c_rsp_resp;

  ccu_snoop_ctrl #(.NbCores(2), .AddrWidth(64), .TimeoutCycles(16)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .req_snoop_i(a_req_snoop), .req_initiator_i(a_req_init),
    .ac_valid_o(a_ac_valid), .ac_ready_i(a_ac_ready), .ac_addr_o(a_ac_addr), .ac_snoop_o(a_ac_snoop),
    .cr_valid_i(a_cr_valid), .cr_ready_o(a_cr_ready), .cr_resp_i(a_cr_resp),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_resp_o(a_rsp_resp),
    .rsp_data_src_o(a_rsp_src), .rsp_timeout_o(a_rsp_tmo)
  );

  ccu_snoop_ctrl #(.NbCores(4), .AddrWidth(64), .TimeoutCycles(64)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .req_snoop_i(b_req_snoop), .req_initiator_i(b_req_init),
    .ac_valid_o(b_ac_valid), .ac_ready_i(b_ac_ready), .ac_addr_o(b_ac_addr), .ac_snoop_o(b_ac_snoop),
    .cr_valid_i(b_cr_valid), .cr_ready_o(b_cr_ready), .cr_resp_i(b_cr_resp),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_resp_o(b_rsp_resp),
    .rsp_data_src_o(b_rsp_src), .rsp_timeout_o(b_rsp_tmo)
  );

  ccu_snoop_ctrl #(.NbCores(1), .AddrWidth(64), .TimeoutCycles(16)) dut_c (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(c_req_valid), .req_ready_o(c_req_ready), .req_addr_i(c_req_addr),
    .req_snoop_i(c_req_snoop), .req_initiator_i(c_req_init),
    .ac_valid_o(c_ac_valid), .ac_ready_i(c_ac_ready), .ac_addr_o(c_ac_addr), .ac_snoop_o(c_ac_snoop),
    .cr_valid_i(c_cr_valid), .cr_ready_o(c_cr_ready), .cr_resp_i(c_cr_resp),
    .rsp_valid_o(c_rsp_valid), .rsp_ready_i(c_rsp_ready), .rsp_resp_o(c_rsp_resp),
    .rsp_data_src_o(c_rsp_src), .rsp_timeout_o(c_rsp_tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until dut_a presents a response; lat = samples waited, -1 if the budget ran out.
  task automatic wait_a_rsp(input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      if (a_rsp_valid) begin
        lat = k;
        break;
      end
      step();
    end
  endtask

  task automatic a_handshake();
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (a_req_ready !== 1'b0 || a_ac_valid !== 2'b00 || a_rsp_valid !== 1'b0 || b_ac_valid !== 4'h0) begin
      failures++;
      $display("FAIL reset_hold: req_ready=%b ac_valid=%b rsp_valid=%b b_ac_valid=%b, required 0 00 0 0000",
               a_req_ready, a_ac_valid, a_rsp_valid, b_ac_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_req_ready, b_req_ready, c_req_ready} !== 3'b111 || a_cr_ready !== 2'b00 || a_rsp_resp !== 5'd0) begin
      failures++;
      $display("FAIL reset_release: req_ready=%b%b%b cr_ready=%b rsp_resp=%b, required 111 00 00000",
               a_req_ready, b_req_ready, c_req_ready, a_cr_ready, a_rsp_resp);
    end
  endtask

  task automatic test_basic();
    a_req_addr = 64'h8000_0000; a_req_snoop = 4'h1; a_req_init = 1'b0;
    a_ac_ready = 2'b10; a_req_valid = 1'b1;
    sb_q.push_back('{resp: 5'b01001, src: 4'b0010, tmo: 1'b0});
    step();
    a_req_valid = 1'b0;
    checks++;
    if (a_ac_valid !== 2'b10 || a_ac_addr !== 64'h8000_0000 || a_ac_snoop !== 4'h1 || a_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_ac_issue: ac_valid=%b addr=%h snoop=%h req_ready=%b, required 10 80000000 1 0",
               a_ac_valid, a_ac_addr, a_ac_snoop, a_req_ready);
    end
    step();
    checks++;
    if (a_ac_valid !== 2'b00) begin
      failures++;
      $display("FAIL basic_ac_one_cycle: ac_valid=%b, required 00", a_ac_valid);
    end
    checks++;
    if (a_cr_ready !== 2'b10 || a_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_cr_ready: cr_ready=%b rsp_valid=%b, required 10 0", a_cr_ready, a_rsp_valid);
    end
    a_cr_valid = 2'b10; a_cr_resp = {5'b01001, 5'b00000};
    step();
    a_cr_valid = 2'b00; a_ac_ready = 2'b00;
    checks++;
    if (a_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: rsp_valid=%b three cycles after accept, required 1", a_rsp_valid);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL basic_rsp: scoreboard empty");
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: a_rsp_resp, src: {2'b00, a_rsp_src}, tmo: a_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL basic_rsp: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    a_handshake();
    checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: req_ready=%b rsp_valid=%b, required 1 0", a_req_ready, a_rsp_valid);
    end
  endtask

  task automatic test_four_cores();
    int lat = -1;
    int core2_bad = 0, addr_bad = 0, early_cr = 0, ac0_bad = 0;
    b_req_addr = 64'h1234_5678_9ABC_DEF0; b_req_snoop = 4'hB; b_req_init = 2'd2;
    b_ac_ready = 4'b1010;
    // Core 0's CR is offered from the start; it must wait for its own AC handshake.
    b_cr_valid = 4'b1011;
    b_cr_resp  = {5'b01000, 5'b00000, 5'b01000, 5'b00100};
    b_req_valid = 1'b1;
    sb_q.push_back('{resp: 5'b01100, src: 4'b0000, tmo: 1'b0});
    step();
    b_req_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (b_rsp_valid) begin
        lat = k;
        break;
      end
      if (b_ac_valid[2] || b_cr_ready[2]) core2_bad++;
      if (b_ac_valid != 4'h0 && b_ac_addr !== 64'h1234_5678_9ABC_DEF0) addr_bad++;
      if (b_cr_ready[0] && b_ac_valid[0]) early_cr++;
      if (k == 5 && b_ac_valid[0] !== 1'b1) ac0_bad++;
      if (k == 6 && b_ac_valid[0] !== 1'b0) ac0_bad++;
      b_ac_ready = (k >= 5) ? 4'b1011 : 4'b1010;
      step();
    end
    b_cr_valid = 4'h0; b_ac_ready = 4'h0;
    checks++;
    if (core2_bad != 0 || early_cr != 0) begin
      failures++;
      $display("FAIL four_initiator_excluded: core2 activity=%0d early cr_ready=%0d, required 0 0", core2_bad, early_cr);
    end
    checks++;
    if (addr_bad != 0 || ac0_bad != 0) begin
      failures++;
      $display("FAIL four_ac_hold: addr changes=%0d core0 ac timing errors=%0d, required 0 0", addr_bad, ac0_bad);
    end
    checks++;
    if (lat != 7) begin
      failures++;
      $display("FAIL four_latency: response after %0d cycles, required 7", lat);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL four_rsp: scoreboard empty");
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: b_rsp_resp, src: b_rsp_src, tmo: b_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL four_rsp: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int lat;
    a_req_addr = 64'h0000_1000; a_req_snoop = 4'h7; a_req_init = 1'b0;
    a_ac_ready = 2'b10; a_req_valid = 1'b1;
    sb_q.push_back('{resp: 5'b00010, src: 4'b0000, tmo: 1'b1});
    step();
    a_req_valid = 1'b0;
    wait_a_rsp(40, lat);
    checks++;
    if (lat != 16) begin
      failures++;
      $display("FAIL timeout_cycles: SNOOP lasted %0d cycles, required 16", lat);
    end
    checks++;
    if (a_cr_ready !== 2'b00 || a_ac_valid !== 2'b00) begin
      failures++;
      $display("FAIL timeout_drop: cr_ready=%b ac_valid=%b in RESP, required 00 00", a_cr_ready, a_ac_valid);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL timeout_rsp: scoreboard empty");
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: a_rsp_resp, src: {2'b00, a_rsp_src}, tmo: a_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL timeout_rsp: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    a_handshake();
    a_ac_ready = 2'b00;
  endtask

  task automatic test_resp_hold();
    int lat;
    int hold_bad = 0;
    logic [10:0] snap;
    a_req_addr = 64'h40; a_req_snoop = 4'h2; a_req_init = 1'b1;
    a_ac_ready = 2'b01; a_cr_valid = 2'b01; a_cr_resp = {5'b00000, 5'b10001};
    a_req_valid = 1'b1;
    sb_q.push_back('{resp: 5'b10001, src: 4'b0001, tmo: 1'b0});
    step();
    a_req_valid = 1'b0;
    wait_a_rsp(20, lat);
    a_cr_valid = 2'b00;
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL hold_latency: response after %0d cycles, required 2", lat);
    end
    snap = {a_rsp_valid, a_rsp_resp, a_rsp_src, a_rsp_tmo, a_req_ready};
    a_req_addr = 64'h80; a_req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if ({a_rsp_valid, a_rsp_resp, a_rsp_src, a_rsp_tmo, a_req_ready} !== snap || a_req_ready !== 1'b0) hold_bad++;
      step();
    end
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL hold_stable: %0d unstable cycles while stalled, required 0", hold_bad);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL hold_rsp: scoreboard empty");
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: a_rsp_resp, src: {2'b00, a_rsp_src}, tmo: a_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL hold_rsp: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    a_handshake();
    checks++;
    if (a_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_ready_after: req_ready=%b after RESP handshake, required 1", a_req_ready);
    end
    a_cr_resp = 10'd0; a_cr_valid = 2'b01;
    sb_q.push_back('{resp: 5'b00000, src: 4'b0000, tmo: 1'b0});
    step();
    a_req_valid = 1'b0;
    checks++;
    if (a_ac_valid !== 2'b01 || a_ac_addr !== 64'h80) begin
      failures++;
      $display("FAIL hold_next_accept: ac_valid=%b addr=%h, required 01 80", a_ac_valid, a_ac_addr);
    end
    wait_a_rsp(20, lat);
    a_cr_valid = 2'b00; a_ac_ready = 2'b00;
    checks++;
    if (sb_q.size() == 0 || lat < 0) begin
      failures++;
      $display("FAIL hold_cleared_rsp: no response (lat=%0d) or scoreboard empty", lat);
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: a_rsp_resp, src: {2'b00, a_rsp_src}, tmo: a_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL hold_cleared_rsp: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    a_handshake();
  endtask

  task automatic test_single_core();
    c_req_addr = 64'hC0; c_req_snoop = 4'h1; c_req_init = 1'b0; c_req_valid = 1'b1;
    sb_q.push_back('{resp: 5'b00000, src: 4'b0000, tmo: 1'b0});
    step();
    c_req_valid = 1'b0;
    checks++;
    if (c_ac_valid !== 1'b0 || c_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_direct: ac_valid=%b rsp_valid=%b, required 0 1", c_ac_valid, c_rsp_valid);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL single_rsp: scoreboard empty");
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: c_rsp_resp, src: {3'b000, c_rsp_src}, tmo: c_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL single_rsp: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    c_rsp_ready = 1'b1;
    step();
    c_rsp_ready = 1'b0;
  endtask

  task automatic test_out_of_range();
    int lat = -1;
    c_req_addr = 64'hE0; c_req_snoop = 4'h9; c_req_init = 1'b1;
    c_ac_ready = 1'b1; c_cr_valid = 1'b1; c_cr_resp = 5'b00001; c_req_valid = 1'b1;
    sb_q.push_back('{resp: 5'b00001, src: 4'b0001, tmo: 1'b0});
    step();
    c_req_valid = 1'b0;
    checks++;
    if (c_ac_valid !== 1'b1) begin
      failures++;
      $display("FAIL oor_target: ac_valid=%b for out-of-range initiator, required 1", c_ac_valid);
    end
    for (int k = 0; k < 20; k++) begin
      if (c_rsp_valid) begin
        lat = k;
        break;
      end
      step();
    end
    c_ac_ready = 1'b0; c_cr_valid = 1'b0;
    checks++;
    if (sb_q.size() == 0 || lat != 2) begin
      failures++;
      $display("FAIL oor_rsp: latency %0d or scoreboard empty, required 2", lat);
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: c_rsp_resp, src: {3'b000, c_rsp_src}, tmo: c_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL oor_rsp: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    c_rsp_ready = 1'b1;
    step();
    c_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    a_req_addr = 64'h2000; a_req_snoop = 4'h1; a_req_init = 1'b0;
    a_ac_ready = 2'b00; a_req_valid = 1'b1;
    step();
    a_req_valid = 1'b0;
    step();
    checks++;
    if (a_ac_valid !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_pre: ac_valid=%b before reset, required 10", a_ac_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_ac_valid !== 2'b00 || a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: ac_valid=%b rsp_valid=%b req_ready=%b during reset, required 00 0 0",
               a_ac_valid, a_rsp_valid, a_req_ready);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_release: req_ready=%b, required 1", a_req_ready);
    end
    a_req_addr = 64'h3000; a_ac_ready = 2'b10; a_cr_valid = 2'b10;
    a_cr_resp = {5'b01000, 5'b00000}; a_req_valid = 1'b1;
    sb_q.push_back('{resp: 5'b01000, src: 4'b0000, tmo: 1'b0});
    step();
    a_req_valid = 1'b0;
    wait_a_rsp(20, lat);
    a_cr_valid = 2'b00; a_ac_ready = 2'b00;
    checks++;
    if (sb_q.size() == 0 || lat != 2) begin
      failures++;
      $display("FAIL rstmid_next: latency %0d or scoreboard empty, required 2", lat);
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = '{resp: a_rsp_resp, src: {2'b00, a_rsp_src}, tmo: a_rsp_tmo};
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL rstmid_next: got resp=%b src=%b tmo=%b, expected resp=%b src=%b tmo=%b",
                 obs_v.resp, obs_v.src, obs_v.tmo, exp_v.resp, exp_v.src, exp_v.tmo);
      end
    end
    a_handshake();
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_addr = 0; a_req_snoop = 0; a_req_init = 0;
    a_ac_ready = 0; a_cr_valid = 0; a_cr_resp = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_addr = 0; b_req_snoop = 0; b_req_init = 0;
    b_ac_ready = 0; b_cr_valid = 0; b_cr_resp = 0; b_rsp_ready = 0;
    c_req_valid = 0; c_req_addr = 0; c_req_snoop = 0; c_req_init = 0;
    c_ac_ready = 0; c_cr_valid = 0; c_cr_resp = 0; c_rsp_ready = 0;
    test_reset();
    test_basic();
    test_four_cores();
    test_timeout();
    test_resp_hold();
    test_single_core();
    test_out_of_range();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses never observed, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
